// File: rtl/sdf_pkg.sv
// Shared types and helpers for the radix-2^2 SDF stage sequencers.
package sdf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAD   = 2'd2,
        DRAIN = 2'd3
    } sdf_state_t;

    // (cnt - off) mod 2^logs
    function automatic logic [31:0] phase_sub(input logic [31:0] cnt,
                                              input logic [31:0] off,
                                              input int          logs);
        return (cnt - off) & ((32'd1 << logs) - 32'd1);
    endfunction

    // (q * r * tws) mod 2^logn, product formed wide then truncated
    function automatic logic [31:0] tw_index(input logic [31:0] q,
                                             input logic [31:0] r,
                                             input logic [31:0] tws,
                                             input int          logn);
        logic [63:0] prod;
        prod = 64'(q) * 64'(r) * 64'(tws);
        return prod[31:0] & ((32'd1 << logn) - 32'd1);
    endfunction

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// Handshake and datapath-control bundle between a stage sequencer and its
// upstream source / datapath.
interface sdf_stage_ctrl_if #(parameter int LOGN = 6);
    logic            enable_in;
    logic            flush;
    logic            in_ready;
    logic            adv;
    logic            bf1_sel;
    logic            bf2_sel;
    logic            mj_sel;
    logic [LOGN-1:0] tw_addr;
    logic            enable_out;
    logic            busy;
    logic            flush_done;

    // upstream / datapath side
    modport master (
        output enable_in, flush,
        input  in_ready, adv, bf1_sel, bf2_sel, mj_sel, tw_addr,
               enable_out, busy, flush_done
    );

    // sequencer side
    modport slave (
        input  enable_in, flush,
        output in_ready, adv, bf1_sel, bf2_sel, mj_sel, tw_addr,
               enable_out, busy, flush_done
    );
endinterface

// File: rtl/sdf_tw_addr_gen.sv
// Combinational twiddle ROM address from the stage's p3 phase.
module sdf_tw_addr_gen
    import sdf_pkg::*;
#(
    parameter int N = 64,
    parameter int S = 64
) (
    input  logic [$clog2(S)-1:0] p3_i,
    output logic [$clog2(N)-1:0] tw_addr_o
);
    localparam int LOGN = $clog2(N);
    localparam int LOGS = $clog2(S);
    localparam int TWS  = N / S;

    generate
        if (S == 4) begin : g_trivial
            assign tw_addr_o = '0;
        end else begin : g_rom
            logic [1:0] q;
            // quarter index is bit-reversed (quarter 1 <-> 2) to match the
            // radix-2^2 exponent order 0,2,1,3
            always_comb begin
                q         = {p3_i[LOGS-2], p3_i[LOGS-1]};
                tw_addr_o = LOGN'(tw_index(32'(q), 32'(p3_i[LOGS-3:0]),
                                           32'(TWS), LOGN));
            end
        end
    endgenerate
endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sample-counter FSM for one radix-2^2 SDF stage: advance/select/twiddle
// control plus a pad-then-drain flush handshake.
module sdf_stage_ctrl
    import sdf_pkg::*;
#(
    parameter int N = 64,
    parameter int S = 64
) (
    input  logic             clk,
    input  logic             rst,
    sdf_stage_ctrl_if.slave  bus
);
    localparam int LOGN = $clog2(N);
    localparam int LOGS = $clog2(S);
    localparam int L    = 3 * S / 4;
    localparam int DW   = $clog2(L);

    sdf_state_t      state_q, state_d;
    logic [LOGS-1:0] cnt_q;
    logic [15:0]     tot_q, r_q;
    logic [DW-1:0]   dcnt_q;

    logic            in_ready, adv, fdone, real_s, eo;
    logic [LOGS-1:0] cnt_inc, cnt_post, p2, p3;
    logic [LOGN-1:0] tw;

    assign cnt_inc = cnt_q + 1'b1;

    // phase views of the sample counter
    always_comb begin
        p2 = LOGS'(phase_sub(32'(cnt_q), 32'(S / 2), LOGS));
        p3 = LOGS'(phase_sub(32'(cnt_q), 32'(L), LOGS));
    end

    sdf_tw_addr_gen #(.N(N), .S(S)) u_tw (
        .p3_i      (p3),
        .tw_addr_o (tw)
    );

    // next state, handshake and advance
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        adv      = 1'b0;
        real_s   = 1'b0;
        fdone    = 1'b0;
        cnt_post = cnt_q;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                adv      = bus.enable_in;
                real_s   = bus.enable_in;
                if (bus.enable_in) state_d = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                adv      = bus.enable_in;
                real_s   = bus.enable_in;
                cnt_post = adv ? cnt_inc : cnt_q;
                if (bus.flush) state_d = (cnt_post != '0) ? PAD : DRAIN;
            end
            PAD: begin
                adv = 1'b1;
                if (cnt_inc == '0) state_d = DRAIN;
            end
            DRAIN: begin
                adv = 1'b1;
                if (dcnt_q == DW'(L - 1)) begin
                    fdone   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // output i is input i-L, so it is real only if that input was real
    assign eo = adv && (tot_q >= 16'(L)) && ((tot_q - 16'(L)) < r_q);

    // drive the bundle; everything is forced low while in reset
    always_comb begin
        bus.in_ready   = in_ready;
        bus.adv        = adv;
        bus.bf1_sel    = cnt_q[LOGS-1];
        bus.bf2_sel    = p2[LOGS-2];
        bus.mj_sel     = p2[LOGS-1] & p2[LOGS-2];
        bus.tw_addr    = tw;
        bus.enable_out = eo;
        bus.busy       = (state_q != IDLE);
        bus.flush_done = fdone;
        if (rst) begin
            bus.in_ready   = 1'b0;
            bus.adv        = 1'b0;
            bus.bf1_sel    = 1'b0;
            bus.bf2_sel    = 1'b0;
            bus.mj_sel     = 1'b0;
            bus.tw_addr    = '0;
            bus.enable_out = 1'b0;
            bus.busy       = 1'b0;
            bus.flush_done = 1'b0;
        end
    end

    // state and counters; counters move only on adv, cleared at end of flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tot_q   <= '0;
            r_q     <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fdone) begin
                cnt_q  <= '0;
                tot_q  <= '0;
                r_q    <= '0;
                dcnt_q <= '0;
            end else if (adv) begin
                cnt_q <= cnt_inc;
                if (tot_q != 16'hFFFF) tot_q <= tot_q + 16'd1;
                if (real_s && r_q != 16'hFFFF) r_q <= r_q + 16'd1;
                if (state_q == DRAIN) dcnt_q <= dcnt_q + 1'b1;
            end
        end
    end
endmodule
